// File: rtl/switch_debouncer_pkg.sv
// Shared definitions for the push-button debouncer: FSM state encoding and
// default timing constants for a 25 MHz board clock.
package switch_debouncer_pkg;

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'd0,
    PEND_HIGH   = 2'd1,
    STABLE_HIGH = 2'd2,
    PEND_LOW    = 2'd3
  } state_e;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 250000;    // 10 ms
  localparam int unsigned DEF_REPEAT_DELAY    = 12500000;  // 500 ms
  localparam int unsigned DEF_REPEAT_PERIOD   = 2500000;   // 100 ms

  function automatic int unsigned maxOf(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/switch_debouncer_sync_2ff.sv
// Two-flop synchroniser bringing an asynchronous input into the i_clk domain.
module sync_2ff (
  input  logic i_clk,
  input  logic i_rstN,
  input  logic i_d,
  output logic o_q
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge i_clk) begin
    if (!i_rstN) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= i_d;
      s2_q <= s1_q;
    end
  end

  assign o_q = s2_q;

endmodule

// File: rtl/switch_debouncer.sv
// Debounces one raw push-button: clean level, press/release strobes and an
// auto-repeat step strobe for the counter/display path.
module switch_debouncer
  import switch_debouncer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_EN       = 1,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic i_clk,
  input  logic i_rstN,
  input  logic i_switch,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_step
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned RW = $clog2(maxOf(REPEAT_DELAY, REPEAT_PERIOD) + 1);
  localparam logic [DW-1:0] DebLast   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] RepDelay  = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] RepPeriod = RW'(REPEAT_PERIOD);

  logic syncSw;

  state_e        state_q,     state_d;
  logic [DW-1:0] debCnt_q,    debCnt_d;
  logic [RW-1:0] repCnt_q,    repCnt_d;
  logic          repeating_q, repeating_d;
  logic          level_q,     level_d;
  logic          press_q,     press_d;
  logic          release_q,   release_d;
  logic          step_q,      step_d;
  logic [RW-1:0] repNext;

  sync_2ff uSync (
    .i_clk  (i_clk),
    .i_rstN (i_rstN),
    .i_d    (i_switch),
    .o_q    (syncSw)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rstN) begin
      state_q     <= STABLE_LOW;
      debCnt_q    <= '0;
      repCnt_q    <= '0;
      repeating_q <= 1'b0;
      level_q     <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      step_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      debCnt_q    <= debCnt_d;
      repCnt_q    <= repCnt_d;
      repeating_q <= repeating_d;
      level_q     <= level_d;
      press_q     <= press_d;
      release_q   <= release_d;
      step_q      <= step_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    debCnt_d    = debCnt_q;
    repCnt_d    = repCnt_q;
    repeating_d = repeating_q;
    level_d     = level_q;
    press_d     = 1'b0;
    release_d   = 1'b0;
    step_d      = 1'b0;
    repNext     = repCnt_q + RW'(1);

    case (state_q)
      STABLE_LOW: begin
        if (syncSw) begin
          state_d  = PEND_HIGH;
          debCnt_d = DW'(1);
        end
      end

      PEND_HIGH: begin
        if (!syncSw) begin
          state_d  = STABLE_LOW;
          debCnt_d = '0;
        end else if (debCnt_q == DebLast) begin
          state_d     = STABLE_HIGH;
          debCnt_d    = '0;
          level_d     = 1'b1;
          press_d     = 1'b1;
          step_d      = 1'b1;
          repCnt_d    = '0;
          repeating_d = 1'b0;
        end else begin
          debCnt_d = debCnt_q + DW'(1);
        end
      end

      // repeating_q selects between the initial delay and the steady period,
      // so the counter restarts from zero after every strobe and never wraps.
      STABLE_HIGH: begin
        if (!syncSw) begin
          state_d  = PEND_LOW;
          debCnt_d = DW'(1);
        end else if (REPEAT_EN != 0) begin
          if ((!repeating_q && repNext == RepDelay) ||
              ( repeating_q && repNext == RepPeriod)) begin
            step_d      = 1'b1;
            repCnt_d    = '0;
            repeating_d = 1'b1;
          end else begin
            repCnt_d = repNext;
          end
        end
      end

      PEND_LOW: begin
        if (syncSw) begin
          state_d  = STABLE_HIGH;
          debCnt_d = '0;
        end else if (debCnt_q == DebLast) begin
          state_d     = STABLE_LOW;
          debCnt_d    = '0;
          level_d     = 1'b0;
          release_d   = 1'b1;
          repCnt_d    = '0;
          repeating_d = 1'b0;
        end else begin
          debCnt_d = debCnt_q + DW'(1);
        end
      end

      default: begin
        state_d = STABLE_LOW;
      end
    endcase
  end

  assign o_level   = level_q;
  assign o_press   = press_q;
  assign o_release = release_q;
  assign o_step    = step_q;

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed self-checking bench for switch_debouncer with a 4-sample window,
// 8-cycle repeat delay and 3-cycle repeat period.
module tb_switch_debouncer;

  logic clk = 1'b0;
  logic rstN;
  logic sw;
  logic level, press, release_s, step;

  int checks   = 0;
  int failures = 0;

  switch_debouncer #(
    .DEBOUNCE_CYCLES (4),
    .REPEAT_EN       (1),
    .REPEAT_DELAY    (8),
    .REPEAT_PERIOD   (3)
  ) dut (
    .i_clk     (clk),
    .i_rstN    (rstN),
    .i_switch  (sw),
    .o_level   (level),
    .o_press   (press),
    .o_release (release_s),
    .o_step    (step)
  );

  always #5 clk = ~clk;

  // Advance one rising edge; inputs change and outputs are sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settleLow();
    logic [3:0] obs;
    sw = 1'b0;
    repeat (12) tick();
    obs = {level, press, release_s, step};
    checks++;
    if (obs !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL settle_low got=%b exp=0000", obs);
    end
  endtask

  task automatic test_reset();
    logic [3:0] obs, exp;
    rstN = 1'b0;
    sw   = 1'b1;
    repeat (2) tick();
    obs = {level, press, release_s, step};
    checks++;
    if (obs !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL reset_outputs got=%b exp=0000", obs);
    end
    rstN = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      obs = {level, press, release_s, step};
      exp = {(k >= 6), (k == 6), 1'b0, (k == 6)};
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("[TB] FAIL reset_first_press k=%0d got=%b exp=%b", k, obs, exp);
      end
    end
    settleLow();
  endtask

  task automatic test_bounce();
    logic [14:0] pat;
    logic [3:0]  obs;
    pat = 15'b000_0000_0110111;
    for (int i = 0; i < 15; i++) begin
      sw = pat[i];
      tick();
      obs = {level, press, release_s, step};
      checks++;
      if (obs !== 4'b0000) begin
        failures++;
        $display("[TB] FAIL bounce_reject i=%0d got=%b exp=0000", i, obs);
      end
    end
  endtask

  task automatic test_press_release();
    logic [3:0] obs, exp;
    logic       expStep;
    sw = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      expStep = (k == 6) || (k == 14) || (k == 17) || (k == 20);
      obs = {level, press, release_s, step};
      exp = {(k >= 6), (k == 6), 1'b0, expStep};
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("[TB] FAIL clean_press k=%0d got=%b exp=%b", k, obs, exp);
      end
    end
    sw = 1'b0;
    for (int j = 1; j <= 10; j++) begin
      tick();
      obs = {level, press, release_s, step};
      exp = {(j < 6), 1'b0, (j == 6), 1'b0};
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("[TB] FAIL clean_release j=%0d got=%b exp=%b", j, obs, exp);
      end
    end
  endtask

  task automatic test_auto_repeat();
    logic [3:0] obs, exp;
    logic       expStep;
    sw = 1'b1;
    for (int k = 1; k <= 36; k++) begin
      tick();
      expStep = (k == 6) || (k >= 14 && ((k - 14) % 3) == 0);
      obs = {level, press, release_s, step};
      exp = {(k >= 6), (k == 6), 1'b0, expStep};
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("[TB] FAIL auto_repeat k=%0d got=%b exp=%b", k, obs, exp);
      end
    end
    settleLow();
  endtask

  // Raw low for two cycles: the repeat counter misses three counting edges
  // (STABLE_HIGH seeing 0, then two PEND_LOW edges), so the strobe due at
  // 26 moves to 29.
  task automatic test_release_bounce();
    logic [3:0] obs, exp;
    logic       expStep;
    sw = 1'b1;
    for (int k = 1; k <= 36; k++) begin
      tick();
      expStep = (k == 6) || (k == 14) || (k == 17) || (k == 20) || (k == 23) ||
                (k == 29) || (k == 32) || (k == 35);
      obs = {level, press, release_s, step};
      exp = {(k >= 6), (k == 6), 1'b0, expStep};
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("[TB] FAIL release_bounce k=%0d got=%b exp=%b", k, obs, exp);
      end
      if (k == 21) sw = 1'b0;
      if (k == 23) sw = 1'b1;
    end
    settleLow();
  endtask

  task automatic test_reset_mid_pend();
    logic [3:0] obs, exp;
    sw = 1'b1;
    repeat (5) tick();
    rstN = 1'b0;
    for (int r = 0; r < 2; r++) begin
      tick();
      obs = {level, press, release_s, step};
      checks++;
      if (obs !== 4'b0000) begin
        failures++;
        $display("[TB] FAIL reset_mid_pend r=%0d got=%b exp=0000", r, obs);
      end
    end
    rstN = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      tick();
      obs = {level, press, release_s, step};
      exp = {(j >= 6), (j == 6), 1'b0, (j == 6)};
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("[TB] FAIL requalify j=%0d got=%b exp=%b", j, obs, exp);
      end
    end
    settleLow();
  endtask

  initial begin
    rstN = 1'b0;
    sw   = 1'b0;
    test_reset();
    test_bounce();
    test_press_release();
    test_auto_repeat();
    test_release_bounce();
    test_reset_mid_pend();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
